// File: rtl/rsa_pkg.sv
// Shared types and helpers for the RSA modular exponentiation datapath.
package rsa_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REDUCE,
        WAIT_R,
        LOOP,
        WAIT_L,
        FIN
    } modexp_state_t;

    // Cycles from the accept edge to the done cycle, for any exponent (n > 1).
    function automatic int modexp_latency(input int w);
        return (w + 1) * (w + 1) + 1;
    endfunction

endpackage

// File: rtl/rsa_modexp_mod_mul_serial.sv
// Bit-serial interleaved modular multiplier: p = a*b mod n, fixed latency WIDTH.
// Requires b < n; a may be any WIDTH value.
module mod_mul_serial #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] n,
    output logic             done,
    output logic [WIDTH-1:0] p
);

    localparam int AW = WIDTH + 2;
    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] n_q;
    logic [CW-1:0]    cnt;
    logic             running;

    // acc < n on entry, so 2*acc + b < 3n: two conditional subtractions suffice.
    function automatic logic [WIDTH-1:0] mm_step(
        input logic [WIDTH-1:0] acc_in,
        input logic             bit_in,
        input logic [WIDTH-1:0] b_in,
        input logic [WIDTH-1:0] n_in
    );
        logic [AW-1:0] t;
        logic [AW-1:0] nn;
        nn = {2'b00, n_in};
        t  = {1'b0, acc_in, 1'b0} + (bit_in ? {2'b00, b_in} : {AW{1'b0}});
        if (t >= nn) t = t - nn;
        if (t >= nn) t = t - nn;
        return t[WIDTH-1:0];
    endfunction

    // The first (MSB) iteration happens on the start edge itself, which keeps
    // the total latency at exactly WIDTH cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc     <= '0;
            a_sh    <= '0;
            b_q     <= '0;
            n_q     <= '0;
            cnt     <= '0;
            running <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                acc     <= mm_step('0, a[WIDTH-1], b, n);
                a_sh    <= {a[WIDTH-2:0], 1'b0};
                b_q     <= b;
                n_q     <= n;
                cnt     <= CW'(WIDTH - 1);
                running <= 1'b1;
            end else if (running) begin
                acc  <= mm_step(acc, a_sh[WIDTH-1], b_q, n_q);
                a_sh <= {a_sh[WIDTH-2:0], 1'b0};
                cnt  <= cnt - 1'b1;
                if (cnt == CW'(1)) begin
                    running <= 1'b0;
                    done    <= 1'b1;
                end
            end
        end
    end

    assign p = acc;

endmodule

// File: rtl/rsa_modexp.sv
// Constant-time right-to-left square-and-multiply: result = base^exponent mod modulus.
//  state  | meaning
//  IDLE   | waiting for start; operands latched on accept
//  REDUCE | issue b = base*1 mod n, init r = 1, i = 0
//  WAIT_R | wait for reduction, load b
//  LOOP   | issue b*r and b*b in parallel
//  WAIT_L | collect products, update r (if exponent[i]) and b, advance i
//  FIN    | done pulse cycle, back to IDLE
module rsa_modexp
    import rsa_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] base,
    input  logic [WIDTH-1:0] exponent,
    input  logic [WIDTH-1:0] modulus,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] result
);

    localparam int IW = $clog2(WIDTH);

    modexp_state_t    state;
    logic [WIDTH-1:0] base_q;
    logic [WIDTH-1:0] exp_q;
    logic [WIDTH-1:0] n_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] r_q;
    logic [IW-1:0]    idx;

    logic             mm0_start;
    logic             mm1_start;
    logic [WIDTH-1:0] mm0_a;
    logic [WIDTH-1:0] mm0_b;
    logic             mm0_done;
    logic             mm1_done;
    logic [WIDTH-1:0] mm0_p;
    logic [WIDTH-1:0] mm1_p;
    logic [WIDTH-1:0] r_next;

    // Multiplier 0 does the base reduction, then b*r; multiplier 1 squares b.
    assign mm0_start = (state == REDUCE) || (state == LOOP);
    assign mm1_start = (state == LOOP);
    assign mm0_a     = (state == REDUCE) ? base_q : b_q;
    assign mm0_b     = (state == REDUCE) ? WIDTH'(1) : r_q;
    assign r_next    = exp_q[idx] ? mm0_p : r_q;

    mod_mul_serial #(.WIDTH(WIDTH)) u_mm_mul (
        .clk   (clk),
        .reset (reset),
        .start (mm0_start),
        .a     (mm0_a),
        .b     (mm0_b),
        .n     (n_q),
        .done  (mm0_done),
        .p     (mm0_p)
    );

    mod_mul_serial #(.WIDTH(WIDTH)) u_mm_sqr (
        .clk   (clk),
        .reset (reset),
        .start (mm1_start),
        .a     (b_q),
        .b     (b_q),
        .n     (n_q),
        .done  (mm1_done),
        .p     (mm1_p)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            base_q <= '0;
            exp_q  <= '0;
            n_q    <= '0;
            b_q    <= '0;
            r_q    <= '0;
            idx    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
            result <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        base_q <= base;
                        exp_q  <= exponent;
                        n_q    <= modulus;
                        result <= '0;
                        err    <= (modulus == '0);
                        // n of 0 or 1 has a trivial answer; skip the loop entirely.
                        if (modulus <= WIDTH'(1)) begin
                            done  <= 1'b1;
                            state <= FIN;
                        end else begin
                            busy  <= 1'b1;
                            state <= REDUCE;
                        end
                    end
                end
                REDUCE: begin
                    r_q   <= WIDTH'(1);
                    idx   <= '0;
                    state <= WAIT_R;
                end
                WAIT_R: begin
                    if (mm0_done) begin
                        b_q   <= mm0_p;
                        state <= LOOP;
                    end
                end
                LOOP: begin
                    state <= WAIT_L;
                end
                WAIT_L: begin
                    if (mm0_done && mm1_done) begin
                        b_q <= mm1_p;
                        r_q <= r_next;
                        if (idx == IW'(WIDTH - 1)) begin
                            result <= r_next;
                            done   <= 1'b1;
                            busy   <= 1'b0;
                            state  <= FIN;
                        end else begin
                            idx   <= idx + 1'b1;
                            state <= LOOP;
                        end
                    end
                end
                FIN: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rsa_modexp.sv
// Directed and random checks of rsa_modexp at WIDTH=16 and WIDTH=8 against a pow model.
module tb_rsa_modexp;
    import rsa_pkg::*;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset16, start16, busy16, done16, err16;
    logic [15:0] base16, exp16, mod16, result16;
    logic        reset8, start8, busy8, done8, err8;
    logic [7:0]  base8, exp8, mod8, result8;

    rsa_modexp #(.WIDTH(16)) dut16 (
        .clk(clk), .reset(reset16), .start(start16), .base(base16), .exponent(exp16),
        .modulus(mod16), .busy(busy16), .done(done16), .err(err16), .result(result16)
    );

    rsa_modexp #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset8), .start(start8), .base(base8), .exponent(exp8),
        .modulus(mod8), .busy(busy8), .done(done8), .err(err8), .result(result8)
    );

    logic        use8 = 1'b0;
    logic        o_busy, o_done, o_err;
    logic [15:0] o_result;
    assign o_busy   = use8 ? busy8 : busy16;
    assign o_done   = use8 ? done8 : done16;
    assign o_err    = use8 ? err8 : err16;
    assign o_result = use8 ? {8'h00, result8} : result16;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Straightforward MSB-first modular power over w exponent bits.
    function automatic longint model(input longint a, input longint e, input longint n, input int w);
        longint r, b;
        if (n <= 1) return 0;
        b = a % n;
        r = 1;
        for (int i = w - 1; i >= 0; i--) begin
            r = (r * r) % n;
            if (e[i]) r = (r * b) % n;
        end
        return r;
    endfunction

    task automatic drive(input logic s, input longint a, input longint e, input longint n);
        if (use8) begin
            start8 = s; base8 = a[7:0]; exp8 = e[7:0]; mod8 = n[7:0];
        end else begin
            start16 = s; base16 = a[15:0]; exp16 = e[15:0]; mod16 = n[15:0];
        end
    endtask

    // Called at a negedge; returns at the negedge of the done cycle.
    task automatic run_op(input bit w8, input longint a, input longint e, input longint n,
                          input longint exp_res, input bit exp_err, input int hold,
                          input int pulse_at, input string tag);
        int  w, lat_exp, k, busy_bad;
        bit  got;
        use8 = w8;
        w = w8 ? 8 : 16;
        lat_exp = (n > 1) ? modexp_latency(w) : 1;
        drive(1'b1, a, e, n);
        repeat (hold) @(negedge clk);
        @(negedge clk);
        drive(1'b0, longint'($urandom), longint'($urandom), longint'($urandom));
        k = 1;
        got = 0;
        busy_bad = 0;
        while (k <= lat_exp + 20) begin
            if (o_done === 1'b1) begin
                got = 1;
                break;
            end
            if (o_busy !== (n > 1)) busy_bad++;
            @(negedge clk);
            k++;
            if (k == pulse_at)
                drive(1'b1, longint'($urandom), longint'($urandom), longint'($urandom_range(2, 60000)));
            else
                drive(1'b0, a, e, n);
        end
        check({tag, "_latency"}, got ? 64'(k) : 64'hFFFF, 64'(lat_exp));
        check({tag, "_result"}, 64'(o_result), 64'(exp_res));
        check({tag, "_err"}, 64'(o_err), 64'(exp_err));
        check({tag, "_busy_at_done"}, 64'(o_busy), 64'd0);
        check({tag, "_busy_during"}, 64'(busy_bad), 64'd0);
    endtask

    task automatic count_dones(input int cycles, output int cnt);
        cnt = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (done16 !== 1'b0) cnt++;
        end
    endtask

    initial begin
        int dcnt;
        longint a, e, n;
        reset16 = 1'b1; reset8 = 1'b1;
        start16 = 1'b0; base16 = '0; exp16 = '0; mod16 = '0;
        start8 = 1'b0;  base8 = '0;  exp8 = '0;  mod8 = '0;
        repeat (3) @(negedge clk);
        reset16 = 1'b0; reset8 = 1'b0;
        @(negedge clk);
        check("reset_busy", 64'(busy16), 64'd0);
        check("reset_done", 64'(done16), 64'd0);
        check("reset_err", 64'(err16), 64'd0);
        check("reset_result", 64'(result16), 64'd0);

        run_op(0, 4, 13, 497, 445, 0, 0, 0, "basic");
        @(negedge clk);
        check("done_one_cycle", 64'(done16), 64'd0);
        check("result_held", 64'(result16), 64'd445);

        run_op(0, 65, 17, 3233, 2790, 0, 0, 0, "rsa_enc");
        run_op(0, 2790, 2753, 3233, 65, 0, 1, 0, "rsa_dec_b2b");
        @(negedge clk);
        run_op(0, 1234, 0, 3233, 1, 0, 0, 0, "exp_zero");
        @(negedge clk);
        run_op(0, 5000, 1, 3233, 1767, 0, 0, 0, "base_ge_n");
        @(negedge clk);
        run_op(0, 0, 9, 3233, 0, 0, 0, 0, "base_zero");
        @(negedge clk);
        run_op(0, 77, 5, 0, 0, 1, 0, 0, "n_zero");
        @(negedge clk);
        check("err_held", 64'(err16), 64'd1);
        run_op(0, 77, 5, 1, 0, 0, 0, 0, "n_one");
        @(negedge clk);

        run_op(0, 4, 13, 497, 445, 0, 0, 50, "start_while_busy");
        count_dones(400, dcnt);
        check("no_extra_done", 64'(dcnt), 64'd0);

        use8 = 1'b0;
        drive(1'b1, 65, 17, 3233);
        @(negedge clk);
        drive(1'b0, 0, 0, 0);
        repeat (99) @(negedge clk);
        reset16 = 1'b1;
        @(negedge clk);
        reset16 = 1'b0;
        check("abort_busy", 64'(busy16), 64'd0);
        check("abort_done", 64'(done16), 64'd0);
        check("abort_err", 64'(err16), 64'd0);
        check("abort_result", 64'(result16), 64'd0);
        count_dones(400, dcnt);
        check("abort_no_done", 64'(dcnt), 64'd0);
        run_op(0, 4, 13, 497, 445, 0, 0, 0, "after_abort");
        @(negedge clk);

        for (int t = 0; t < 400; t++) begin
            a = longint'($urandom_range(0, 255));
            e = longint'($urandom_range(0, 255));
            n = longint'($urandom_range(2, 255));
            run_op(1, a, e, n, model(a, e, n, 8), 0, 0, 0, "sweep8");
            @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
